// File: rtl/spi_peripheral_responder_pkg.sv
// Shared protocol definitions for the SPI peripheral responder:
// frame states and byte/opcode constants.
package spi_proto_pkg;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR,
    S_WDATA,
    S_COUNT,
    S_RDATA
  } state_e;

  localparam int OPCODE_WRITE_BIT = 0;
  localparam int BYTE_BITS        = 8;

endpackage

// File: rtl/spi_peripheral_responder_if.sv
// SPI pins and host-side register/strobe signals of the responder.
// The slave modport is the chip side; the master modport is the board side.
interface spi_peripheral_responder_if;

  logic       spi_clk;
  logic       serial_in;
  logic       serial_out;
  logic [7:0] host_rd_addr;
  logic [7:0] host_rd_data;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_error;

  modport slave (
    input  spi_clk, serial_in, host_rd_addr,
    output serial_out, host_rd_data, wr_strobe, wr_addr, wr_data, busy, frame_error
  );

  modport master (
    output spi_clk, serial_in, host_rd_addr,
    input  serial_out, host_rd_data, wr_strobe, wr_addr, wr_data, busy, frame_error
  );

endinterface

// File: rtl/spi_peripheral_responder_edge_sync.sv
// Brings spi_clk and serial_in into the clk domain and turns spi_clk
// transitions into single-cycle rise/fall pulses with serial_in kept aligned.
module spi_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic spi_clk_i,
  input  logic serial_in_i,
  output logic rise_o,
  output logic fall_o,
  output logic sdata_o
);

  logic [2:0] sclk_q;
  logic [1:0] sdat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      sdat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk_i};
      sdat_q <= {sdat_q[0], serial_in_i};
    end
  end

  // Data tap matches the second clock flop, so sdata_o is valid with rise_o.
  assign rise_o  = sclk_q[1] & ~sclk_q[2];
  assign fall_o  = ~sclk_q[1] & sclk_q[2];
  assign sdata_o = sdat_q[1];

endmodule

// File: rtl/spi_peripheral_responder.sv
// SPI responder: decodes write and burst-read frames against an N_REGS x 8
// register file, shifts read data back and aborts stalled frames.
module spi_peripheral_responder
  import spi_proto_pkg::*;
#(
  parameter int         N_REGS         = 32,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] RESET_VALUE    = 8'h00
) (
  input  logic                      clk,
  input  logic                      rstn,
  spi_peripheral_responder_if.slave bus
);

  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          rise, fall, sdata;
  logic [7:0]    regs_q [N_REGS];
  state_e        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [6:0]    rxShift_q, rxShift_d;
  logic          isWrite_q, isWrite_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    remain_q, remain_d;
  logic [7:0]    rdAddr_q, rdAddr_d;
  logic [7:0]    txShift_q, txShift_d;
  logic          byteDone_q, byteDone_d;
  logic          errSent_q, errSent_d;
  logic [TW-1:0] idleCnt_q, idleCnt_d;
  logic          wrStrobe_q, wrStrobe_d;
  logic [7:0]    wrAddr_q, wrAddr_d;
  logic [7:0]    wrData_q, wrData_d;
  logic          frameErr_q, frameErr_d;
  logic          commitEn;
  logic [7:0]    rxByte;
  logic          busy;

  spi_edge_sync u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk_i  (bus.spi_clk),
    .serial_in_i(bus.serial_in),
    .rise_o     (rise),
    .fall_o     (fall),
    .sdata_o    (sdata)
  );

  function automatic logic inRange(input logic [7:0] a);
    return int'(a) < N_REGS;
  endfunction

  function automatic logic [7:0] rdValue(input logic [7:0] a);
    if (inRange(a)) return regs_q[a[AW-1:0]];
    return 8'h00;
  endfunction

  assign rxByte = {rxShift_q, sdata};
  assign busy   = (state_q != S_OPCODE) || (bitCnt_q != 3'd0);

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    isWrite_d  = isWrite_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    rdAddr_d   = rdAddr_q;
    txShift_d  = txShift_q;
    byteDone_d = byteDone_q;
    errSent_d  = errSent_q;
    idleCnt_d  = idleCnt_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    frameErr_d = 1'b0;
    commitEn   = 1'b0;

    if (rise || fall) idleCnt_d = '0;
    else if (idleCnt_q != TW'(TIMEOUT_CYCLES)) idleCnt_d = idleCnt_q + 1'b1;

    if (!(rise || fall) && busy && idleCnt_q == TW'(TIMEOUT_CYCLES)) begin
      state_d    = S_OPCODE;
      bitCnt_d   = 3'd0;
      frameErr_d = 1'b1;
      idleCnt_d  = '0;
    end else begin
      if (rise) begin
        rxShift_d = rxByte[6:0];
        bitCnt_d  = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'(BYTE_BITS - 1)) begin
          unique case (state_q)
            S_OPCODE: begin
              isWrite_d = rxByte[OPCODE_WRITE_BIT];
              state_d   = S_ADDR;
            end
            S_ADDR: begin
              addr_d  = rxByte;
              state_d = isWrite_q ? S_WDATA : S_COUNT;
            end
            S_WDATA: begin
              state_d = S_OPCODE;
              if (inRange(addr_q)) begin
                commitEn   = 1'b1;
                wrStrobe_d = 1'b1;
                wrAddr_d   = addr_q;
                wrData_d   = rxByte;
              end else begin
                frameErr_d = 1'b1;
              end
            end
            S_COUNT: begin
              if (rxByte == 8'd0) begin
                state_d = S_OPCODE;
              end else begin
                state_d    = S_RDATA;
                remain_d   = rxByte;
                rdAddr_d   = addr_q;
                txShift_d  = rdValue(addr_q);
                byteDone_d = 1'b1;
                errSent_d  = !inRange(addr_q);
                frameErr_d = !inRange(addr_q);
              end
            end
            S_RDATA: begin
              remain_d   = remain_q - 8'd1;
              rdAddr_d   = rdAddr_q + 8'd1;
              byteDone_d = 1'b1;
              if (remain_q == 8'd1) state_d = S_OPCODE;
            end
            default: state_d = S_OPCODE;
          endcase
        end
      end
      // The first fall after a completed byte reloads, so the MSB is held
      // for the initiator's next rising edge instead of being shifted away.
      if (fall && state_q == S_RDATA) begin
        if (byteDone_q) begin
          txShift_d  = rdValue(rdAddr_q);
          byteDone_d = 1'b0;
          if (!inRange(rdAddr_q) && !errSent_q) begin
            frameErr_d = 1'b1;
            errSent_d  = 1'b1;
          end
        end else begin
          txShift_d = {txShift_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_OPCODE;
      bitCnt_q   <= '0;
      rxShift_q  <= '0;
      isWrite_q  <= 1'b0;
      addr_q     <= '0;
      remain_q   <= '0;
      rdAddr_q   <= '0;
      txShift_q  <= '0;
      byteDone_q <= 1'b0;
      errSent_q  <= 1'b0;
      idleCnt_q  <= '0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      isWrite_q  <= isWrite_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      rdAddr_q   <= rdAddr_d;
      txShift_q  <= txShift_d;
      byteDone_q <= byteDone_d;
      errSent_q  <= errSent_d;
      idleCnt_q  <= idleCnt_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else if (commitEn) begin
      regs_q[addr_q[AW-1:0]] <= rxByte;
    end
  end

  assign bus.serial_out   = (state_q == S_RDATA) ? txShift_q[7] : 1'b0;
  assign bus.host_rd_data = rdValue(bus.host_rd_addr);
  assign bus.wr_strobe    = wrStrobe_q;
  assign bus.wr_addr      = wrAddr_q;
  assign bus.wr_data      = wrData_q;
  assign bus.busy         = busy;
  assign bus.frame_error  = frameErr_q;

endmodule

// File: tb/tb_spi_peripheral_responder.sv
// Bench for spi_peripheral_responder: directed frame table, hand-built
// timeout/count-zero/reset sequences, then random frames against a register model.
module tb_spi_peripheral_responder;

  localparam int N_REGS  = 32;
  localparam int TIMEOUT = 64;
  localparam int HALF    = 60;

  typedef struct packed {
    logic        isWrite;
    logic [7:0]  addr;
    logic [7:0]  arg;
    logic [31:0] expWord;
    logic [1:0]  expErr;
    logic        expStrobe;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_peripheral_responder_if bus ();

  spi_peripheral_responder #(
    .N_REGS        (N_REGS),
    .TIMEOUT_CYCLES(TIMEOUT),
    .RESET_VALUE   (8'h00)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         errPulses = 0;
  int         strobePulses = 0;
  int         errBase, strobeBase;
  logic [7:0] model [N_REGS];
  logic [7:0] rxQ [$];
  logic [7:0] cmdRx;
  vec_t       vecs [13];

  always @(negedge clk) begin
    if (bus.frame_error === 1'b1) errPulses++;
    if (bus.wr_strobe === 1'b1) strobePulses++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Mode-0 initiator: drive MSB first, sample serial_out just before each rise.
  task automatic spiBits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.serial_in = b[i];
      #(HALF);
      rx[i] = bus.serial_out;
      bus.spi_clk = 1'b1;
      #(HALF);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic isWrite, input logic [7:0] addr, input logic [7:0] arg, input bit noGap);
    logic [7:0] rx;
    @(posedge clk);
    #1;
    rxQ.delete();
    cmdRx      = 8'h00;
    errBase    = errPulses;
    strobeBase = strobePulses;
    spiBits({7'($urandom), isWrite}, 8, rx);
    cmdRx |= rx;
    spiBits(addr, 8, rx);
    cmdRx |= rx;
    spiBits(arg, 8, rx);
    cmdRx |= rx;
    if (!isWrite && arg != 8'd0) begin
      checkOutput("busyDuringRead", {31'd0, bus.busy}, 32'd1);
      for (int k = 0; k < int'(arg); k++) begin
        spiBits(8'($urandom), 8, rx);
        rxQ.push_back(rx);
      end
    end
    if (!noGap) repeat (8) @(posedge clk);
    #1;
  endtask

  // Reference: registers as a plain array; reads walk addresses mod 256.
  function automatic vec_t modelFrame(input logic isWrite, input logic [7:0] addr, input logic [7:0] arg);
    vec_t v;
    logic [7:0] a;
    v = '{isWrite: isWrite, addr: addr, arg: arg, expWord: 32'd0, expErr: 2'd0, expStrobe: 1'b0};
    if (isWrite) begin
      if (int'(addr) < N_REGS) begin
        model[int'(addr)] = arg;
        v.expStrobe = 1'b1;
      end else begin
        v.expErr = 2'd1;
      end
    end else begin
      for (int k = 0; k < int'(arg); k++) begin
        a = addr + 8'(k);
        if (int'(a) >= N_REGS) v.expErr = 2'd1;
        else if (k < 4) v.expWord[31-8*k -: 8] = model[int'(a)];
      end
    end
    return v;
  endfunction

  task automatic checkFrame(input string tag, input vec_t v);
    checkOutput({tag, "/cmdSerialOut"}, {24'd0, cmdRx}, 32'd0);
    checkOutput({tag, "/frameError"}, errPulses - errBase, {30'd0, v.expErr});
    checkOutput({tag, "/wrStrobe"}, strobePulses - strobeBase, {31'd0, v.expStrobe});
    checkOutput({tag, "/busyIdle"}, {31'd0, bus.busy}, 32'd0);
    if (v.isWrite && v.expStrobe) begin
      checkOutput({tag, "/wrAddr"}, {24'd0, bus.wr_addr}, {24'd0, v.addr});
      checkOutput({tag, "/wrData"}, {24'd0, bus.wr_data}, {24'd0, v.arg});
      bus.host_rd_addr = v.addr;
      #1;
      checkOutput({tag, "/hostRead"}, {24'd0, bus.host_rd_data}, {24'd0, v.arg});
    end
    if (!v.isWrite) begin
      checkOutput({tag, "/rdCount"}, rxQ.size(), {24'd0, v.arg});
      for (int k = 0; k < rxQ.size() && k < 4; k++)
        checkOutput($sformatf("%s/rdByte%0d", tag, k), {24'd0, rxQ[k]}, {24'd0, v.expWord[31-8*k -: 8]});
    end
  endtask

  initial begin
    vec_t       v;
    logic [7:0] rx, ha, ra, rarg;
    logic       rw;

    bus.spi_clk      = 1'b0;
    bus.serial_in    = 1'b0;
    bus.host_rd_addr = 8'h00;
    foreach (model[i]) model[i] = 8'h00;

    vecs[0]  = '{1'b1, 8'h05, 8'h3C, 32'h0,        2'd0, 1'b1};
    vecs[1]  = '{1'b1, 8'h02, 8'hA1, 32'h0,        2'd0, 1'b1};
    vecs[2]  = '{1'b1, 8'h03, 8'hB2, 32'h0,        2'd0, 1'b1};
    vecs[3]  = '{1'b1, 8'h04, 8'hC3, 32'h0,        2'd0, 1'b1};
    vecs[4]  = '{1'b1, 8'h1E, 8'h99, 32'h0,        2'd0, 1'b1};
    vecs[5]  = '{1'b1, 8'h1F, 8'h5A, 32'h0,        2'd0, 1'b1};
    vecs[6]  = '{1'b1, 8'h28, 8'h77, 32'h0,        2'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h02, 8'h03, 32'hA1B2C300, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h1E, 8'h04, 32'h995A0000, 2'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h05, 8'h01, 32'h3C000000, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 8'h1F, 8'h02, 32'h5A000000, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 8'h05, 8'h3D, 32'h0,        2'd0, 1'b1};
    vecs[12] = '{1'b0, 8'h04, 8'h02, 32'hC33D0000, 2'd0, 1'b0};

    repeat (4) @(posedge clk);
    #1;
    checkOutput("resetOutputs", {bus.busy, bus.serial_out, bus.wr_strobe, bus.frame_error}, 32'd0);
    checkOutput("resetWrRegs", {bus.wr_addr, bus.wr_data}, 32'd0);
    checkOutput("resetHostRead", {24'd0, bus.host_rd_data}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      void'(modelFrame(vecs[i].isWrite, vecs[i].addr, vecs[i].arg));
      applyStimulus(vecs[i].isWrite, vecs[i].addr, vecs[i].arg, 1'b0);
      checkFrame($sformatf("vec%0d", i), vecs[i]);
    end

    // Write stalled two bits into the data byte must abort, not commit.
    @(posedge clk);
    #1;
    errBase    = errPulses;
    strobeBase = strobePulses;
    spiBits(8'h01, 8, rx);
    spiBits(8'h07, 8, rx);
    spiBits(8'hFF, 2, rx);
    checkOutput("toBusyPartial", {31'd0, bus.busy}, 32'd1);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    checkOutput("toFrameError", errPulses - errBase, 32'd1);
    checkOutput("toNoStrobe", strobePulses - strobeBase, 32'd0);
    checkOutput("toBusyCleared", {31'd0, bus.busy}, 32'd0);
    bus.host_rd_addr = 8'h07;
    #1;
    checkOutput("toRegUnchanged", {24'd0, bus.host_rd_data}, {24'd0, model[7]});
    v = modelFrame(1'b1, 8'h07, 8'hE5);
    applyStimulus(1'b1, 8'h07, 8'hE5, 1'b0);
    checkFrame("afterTimeout", v);

    // Zero-count read, then the next opcode straight away.
    applyStimulus(1'b0, 8'h02, 8'h00, 1'b1);
    checkOutput("cnt0Busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("cnt0SerialOut", {24'd0, cmdRx}, 32'd0);
    checkOutput("cnt0NoError", errPulses - errBase, 32'd0);
    v = modelFrame(1'b1, 8'h06, 8'h6D);
    applyStimulus(1'b1, 8'h06, 8'h6D, 1'b0);
    checkFrame("afterCount0", v);

    // Reset in the middle of a response byte from reg 2.
    @(posedge clk);
    #1;
    spiBits(8'h00, 8, rx);
    spiBits(8'h02, 8, rx);
    spiBits(8'h02, 8, rx);
    spiBits(8'h00, 2, rx);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midByteSerialOut", {31'd0, bus.serial_out}, {31'd0, model[2][5]});
    rstn = 1'b0;
    #1;
    checkOutput("rstSerialOut", {31'd0, bus.serial_out}, 32'd0);
    checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
    bus.host_rd_addr = 8'h05;
    #1;
    checkOutput("rstRegValue", {24'd0, bus.host_rd_data}, 32'd0);
    foreach (model[i]) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    v = modelFrame(1'b1, 8'h09, 8'h42);
    applyStimulus(1'b1, 8'h09, 8'h42, 1'b0);
    checkFrame("afterResetWr", v);
    v = modelFrame(1'b0, 8'h08, 8'h02);
    applyStimulus(1'b0, 8'h08, 8'h02, 1'b0);
    checkFrame("afterResetRd", v);

    for (int n = 0; n < 30; n++) begin
      rw   = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 39));
      rarg = rw ? 8'($urandom) : 8'($urandom_range(0, 4));
      v = modelFrame(rw, ra, rarg);
      applyStimulus(rw, ra, rarg, 1'b0);
      checkFrame($sformatf("rand%0d", n), v);
      ha = 8'($urandom_range(0, 47));
      bus.host_rd_addr = ha;
      #1;
      checkOutput($sformatf("rand%0d/hostPort", n), {24'd0, bus.host_rd_data},
                  {24'd0, (int'(ha) < N_REGS) ? model[int'(ha)] : 8'h00});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
